// File: rtl/fc_argmax_10.sv
// Argmax over one frame of signed neuron sums from the final fully-connected stage.
// Emits the winning class index, its score saturated to OUT_WIDTH, and a frame-length error flag.
module fc_argmax_10 #(
   parameter int IN_WIDTH    = 64,
   parameter int NUM_CLASSES = 10,
   parameter int IDX_WIDTH   = 4,
   parameter int OUT_WIDTH   = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [IN_WIDTH-1:0]  in_data,
   input  logic                 in_valid,
   input  logic                 in_last,
   output logic                 in_ready,
   output logic [IDX_WIDTH-1:0] out_class,
   output logic [OUT_WIDTH-1:0] out_max,
   output logic                 out_err,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [1:0]           o_dbg_state
);

   // Handshakes: a beat moves when in_valid && in_ready at a rising edge;
   // a result moves when out_valid && out_ready at a rising edge.

   localparam int CNT_W = $clog2(NUM_CLASSES + 1);
   localparam logic signed [IN_WIDTH-1:0] SAT_HI =
      {{(IN_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [IN_WIDTH-1:0] SAT_LO =
      {{(IN_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_OUT     = 2'd2
   } state_t;

   state_t                      r_state;
   state_t                      w_next;
   logic                        r_rdy_en;
   logic signed [IN_WIDTH-1:0]  r_max;
   logic [IDX_WIDTH-1:0]        r_idx;
   logic [CNT_W-1:0]            r_cnt;
   logic                        r_out_valid;
   logic [IDX_WIDTH-1:0]        r_out_class;
   logic [OUT_WIDTH-1:0]        r_out_max;
   logic                        r_out_err;

   logic                        w_acc;
   logic                        w_out_hs;
   logic                        w_first;
   logic [CNT_W-1:0]            w_beat;
   logic                        w_final;
   logic                        w_close;
   logic                        w_take;
   logic signed [IN_WIDTH-1:0]  w_new_max;
   logic [IDX_WIDTH-1:0]        w_new_idx;
   logic [OUT_WIDTH-1:0]        w_sat;

   // r_rdy_en keeps in_ready low until the first edge after reset release
   assign in_ready    = r_rdy_en & (r_state != S_OUT);
   assign w_acc       = in_valid & in_ready;
   assign w_out_hs    = r_out_valid & out_ready;
   assign w_first     = (r_state == S_IDLE);
   assign w_beat      = w_first ? '0 : r_cnt;
   assign w_final     = (w_beat == CNT_W'(NUM_CLASSES - 1));
   assign w_close     = w_acc & (w_final | in_last);
   // Strict compare keeps the earliest index on ties
   assign w_take      = w_first | ($signed(in_data) > r_max);
   assign w_new_max   = w_take ? $signed(in_data) : r_max;
   assign w_new_idx   = w_take ? IDX_WIDTH'(w_beat) : r_idx;

   always_comb begin
      w_sat = w_new_max[OUT_WIDTH-1:0];
      if (w_new_max > SAT_HI)
         w_sat = SAT_HI[OUT_WIDTH-1:0];
      else if (w_new_max < SAT_LO)
         w_sat = SAT_LO[OUT_WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_COLLECT: begin
            if (w_close)
               w_next = S_OUT;
            else if (w_acc)
               w_next = S_COLLECT;
         end
         S_OUT: begin
            if (w_out_hs)
               w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdy_en    <= 1'b0;
         r_max       <= '0;
         r_idx       <= '0;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_out_class <= '0;
         r_out_max   <= '0;
         r_out_err   <= 1'b0;
      end else begin
         r_rdy_en <= 1'b1;
         if (w_acc) begin
            r_max <= w_new_max;
            r_idx <= w_new_idx;
            r_cnt <= w_beat + CNT_W'(1);
         end
         if (w_close) begin
            r_out_valid <= 1'b1;
            r_out_class <= w_new_idx;
            r_out_max   <= w_sat;
            r_out_err   <= in_last ^ w_final;
         end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
            r_max       <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
         end
      end
   end

   assign out_valid   = r_out_valid;
   assign out_class   = r_out_class;
   assign out_max     = r_out_max;
   assign out_err     = r_out_err;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fc_argmax_10.sv
// Directed bench for fc_argmax_10: hand-computed frames, saturation, framing errors,
// output back-pressure and mid-frame reset.
module tb_fc_argmax_10;

   logic        clk;
   logic        rst_n;
   logic [63:0] in_data;
   logic        in_valid;
   logic        in_last;
   logic        in_ready;
   logic [3:0]  out_class;
   logic [31:0] out_max;
   logic        out_err;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  o_dbg_state;

   int          n_checks;
   int          n_errors;
   logic [63:0] fd [10];

   fc_argmax_10 dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_last     (in_last),
      .in_ready    (in_ready),
      .out_class   (out_class),
      .out_max     (out_max),
      .out_err     (out_err),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .o_dbg_state (o_dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Sends beats 0..n-1 of fd; in_last is raised on beat last_at (-1: never).
   task automatic send_frame(input int n, input int last_at);
      for (int i = 0; i < n; i++) begin
         int guard;
         in_valid = 1'b1;
         in_data  = fd[i];
         in_last  = (i == last_at);
         guard    = 0;
         while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
         end
         if (guard >= 100) check("beat_accept_timeout", in_ready, 1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Called one cycle after the closing beat; then consumes the result.
   task automatic expect_result(input string tag, input logic [3:0] cls,
                                input logic [31:0] mx, input logic err);
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_class"}, out_class, cls);
      check({tag, "_max"},   out_max, mx);
      check({tag, "_err"},   out_err, err);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_valid_drop"}, out_valid, 0);
      check({tag, "_in_ready"},   in_ready, 1);
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      rst_n     = 1'b0;
      in_data   = '0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready",  in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_class", out_class, 0);
      check("rst_out_max",   out_max, 0);
      check("rst_out_err",   out_err, 0);
      check("rst_state",     o_dbg_state, 0);
      rst_n = 1'b1;
      #1;
      check("rel_in_ready_low", in_ready, 0);
      @(posedge clk); #1;
      check("rel_in_ready_high", in_ready, 1);

      // Basic frame
      fd = '{64'd5, -64'sd3, 64'd100, 64'd7, 64'd0, 64'd99, -64'sd50, 64'd1, 64'd2, 64'd3};
      send_frame(10, 9);
      expect_result("basic", 4'd2, 32'd100, 1'b0);

      // All equal negatives: first index wins
      for (int i = 0; i < 10; i++) fd[i] = -64'sd7;
      send_frame(10, 9);
      expect_result("tie_neg", 4'd0, 32'hFFFF_FFF9, 1'b0);

      // Positive saturation
      for (int i = 0; i < 10; i++) fd[i] = 64'd0;
      fd[4] = 64'h0000_0001_0000_0000;
      send_frame(10, 9);
      expect_result("sat_hi", 4'd4, 32'h7FFF_FFFF, 1'b0);

      // Negative saturation
      for (int i = 0; i < 10; i++) fd[i] = 64'hFFFF_FF00_0000_0000;
      send_frame(10, 9);
      expect_result("sat_lo", 4'd0, 32'h8000_0000, 1'b0);

      // Early in_last on beat 5
      fd = '{64'd1, 64'd2, 64'd3, 64'd50, 64'd4, 64'd5, 64'd0, 64'd0, 64'd0, 64'd0};
      send_frame(6, 5);
      check("early_state", o_dbg_state, 2);
      expect_result("early_last", 4'd3, 32'd50, 1'b1);

      // Ten beats with no in_last
      fd = '{64'd3, 64'd1, 64'd4, 64'd1, 64'd5, 64'd9, 64'd2, 64'd6, 64'd5, 64'd3};
      send_frame(10, -1);
      expect_result("no_last", 4'd5, 32'd9, 1'b1);

      // Normal frame after errors, later equal value must not win
      fd = '{64'd10, 64'd95, 64'd30, 64'd40, 64'd50, 64'd60, 64'd70, 64'd80, 64'd90, 64'd95};
      send_frame(10, 9);
      expect_result("recover", 4'd1, 32'd95, 1'b0);

      // Output back-pressure with upstream pushing
      for (int i = 0; i < 10; i++) fd[i] = 64'(i + 1);
      send_frame(10, 9);
      in_valid = 1'b1;
      in_data  = 64'd1000;
      in_last  = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check("stall_valid", out_valid, 1);
         check("stall_class", out_class, 9);
         check("stall_max",   out_max, 10);
         check("stall_ready", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("stall_release_ready", in_ready, 1);
      check("stall_release_valid", out_valid, 0);
      fd = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6, 64'd77, 64'd7, 64'd8, 64'd9};
      send_frame(10, 9);
      expect_result("post_stall", 4'd6, 32'd77, 1'b0);

      // Reset after beat 6 of a frame
      fd = '{64'd1, 64'd2, 64'd500, 64'd4, 64'd5, 64'd6, 64'd7, 64'd0, 64'd0, 64'd0};
      send_frame(7, -1);
      rst_n = 1'b0;
      #1;
      check("midrst_state",     o_dbg_state, 0);
      check("midrst_in_ready",  in_ready, 0);
      check("midrst_out_valid", out_valid, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("midrst_rel_ready", in_ready, 1);
      fd = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6, 64'd7, 64'd60, 64'd8, 64'd9};
      send_frame(10, 9);
      expect_result("after_rst", 4'd7, 32'd60, 1'b0);

      // Reset while a result is pending
      for (int i = 0; i < 10; i++) fd[i] = 64'd0;
      fd[3] = 64'd42;
      send_frame(10, 9);
      check("outrst_pre_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      check("outrst_valid", out_valid, 0);
      check("outrst_class", out_class, 0);
      check("outrst_max",   out_max, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("outrst_no_result", out_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
